// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: widths, opcode set and
// the decoded instruction layout.
package cpu_pkg;
    localparam int IW  = 9;
    localparam int PCW = 8;
    localparam int RW  = 4;
    localparam int DW  = 8;

    typedef enum logic [3:0] {
        HALT, LDI, SHL, PUT, GET, ADD, SUB, XOR,
        AND, LD, ST, POPC, SLT, BEQZ, BNEZ, JMP
    } op_e;

    // r is imm[3:0]; imm[4] only matters for LDI.
    typedef struct packed {
        op_e        op;
        logic [4:0] imm;
    } instr_t;

    function automatic logic [DW-1:0] popcount(input logic [DW-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) c = c + DW'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/cpu_alu.sv
// Decode and execute: produces the register-file write, memory write,
// branch decision and halt request for the current instruction.
module cpu_alu
    import cpu_pkg::*;
(
    input  op_e           op,
    input  logic [4:0]    imm,
    input  logic [DW-1:0] r0,
    input  logic [DW-1:0] rr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] result,
    output logic          rf_we,
    output logic          rf_to_r,
    output logic          mem_we,
    output logic          br_taken,
    output logic          is_halt
);
    always_comb begin
        result   = r0;
        rf_we    = 1'b0;
        rf_to_r  = 1'b0;
        mem_we   = 1'b0;
        br_taken = 1'b0;
        is_halt  = 1'b0;
        case (op)
            HALT: is_halt = 1'b1;
            LDI:  begin result = DW'(imm);        rf_we = 1'b1; end
            SHL:  begin result = r0 << imm[2:0];  rf_we = 1'b1; end
            PUT:  begin result = r0; rf_we = 1'b1; rf_to_r = 1'b1; end
            GET:  begin result = rr;              rf_we = 1'b1; end
            ADD:  begin result = r0 + rr;         rf_we = 1'b1; end
            SUB:  begin result = r0 - rr;         rf_we = 1'b1; end
            XOR:  begin result = r0 ^ rr;         rf_we = 1'b1; end
            AND:  begin result = r0 & rr;         rf_we = 1'b1; end
            LD:   begin result = mem_rdata;       rf_we = 1'b1; end
            ST:   mem_we = 1'b1;
            POPC: begin result = popcount(rr);    rf_we = 1'b1; end
            SLT:  begin result = DW'(r0 < rr);    rf_we = 1'b1; end
            BEQZ: br_taken = (r0 == '0);
            BNEZ: br_taken = (r0 != '0);
            JMP:  br_taken = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/cpu_data_mem.sv
// 256-byte data memory: combinational read, write on posedge.
module cpu_data_mem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] my_memory [2**AW];

    always_ff @(posedge CLK) begin
        if (we) my_memory[addr] <= wdata;
    end

    assign rdata = my_memory[addr];
endmodule

// File: rtl/cpu_fetch.sv
// Fetch unit: program counter, next-PC selection and the instruction ROM.
module cpu_fetch #(
    parameter int IW  = 9,
    parameter int PCW = 8
) (
    input  logic           CLK,
    input  logic           start,
    input  logic           hold,
    input  logic           br_taken,
    input  logic [PCW-1:0] target,
    output logic [PCW-1:0] pc,
    output logic [IW-1:0]  instr
);
    logic [PCW-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q + PCW'(1);
        if (hold)          pc_d = pc_q;
        else if (br_taken) pc_d = target;
    end

    always_ff @(posedge CLK) begin
        if (start) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    assign pc = pc_q;

    cpu_irom #(.IW(IW), .PCW(PCW)) iROM (
        .addr (pc_q),
        .data (instr)
    );
endmodule

// File: rtl/cpu_irom.sv
// Instruction ROM, combinational read. Contents are loaded from outside
// through hierarchical writes.
module cpu_irom #(
    parameter int IW  = 9,
    parameter int PCW = 8
) (
    input  logic [PCW-1:0] addr,
    output logic [IW-1:0]  data
);
    logic [IW-1:0] instruction_memory [2**PCW];

    assign data = instruction_memory[addr];
endmodule

// File: rtl/cpu_reg_file.sv
// Sixteen 8-bit registers, two combinational reads (R0 and R[r]), one write.
module cpu_reg_file #(
    parameter int DW = 8,
    parameter int RW = 4
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] r0
);
    logic [DW-1:0] registers [2**RW];

    always_ff @(posedge CLK) begin
        if (we) registers[waddr] <= wdata;
    end

    assign rdata = registers[raddr];
    assign r0    = registers[0];
endmodule

// File: rtl/top_level.sv
// Single-cycle 8-bit accumulator CPU: fetch, combinational decode/ALU,
// register file and data memory, with a sticky Halt flag.
module top_level #(
    parameter int IW  = 9,
    parameter int PCW = 8
) (
    input  logic CLK,
    input  logic start,
    output logic Halt
);
    import cpu_pkg::*;

    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
    instr_t         dec;
    logic [DW-1:0]  r0, rr, mem_rdata, result;
    logic           rf_we, rf_to_r, mem_we, br_taken, is_halt;
    logic           wr_ok;
    logic           halt_q, halt_d;

    assign dec = instr_t'(instr[8:0]);
    // Nothing commits while held in start or once halted.
    assign wr_ok = ~start & ~halt_q;

    cpu_fetch #(.IW(IW), .PCW(PCW)) IF (
        .CLK      (CLK),
        .start    (start),
        .hold     (is_halt | halt_q),
        .br_taken (br_taken),
        .target   (PCW'(rr)),
        .pc       (pc),
        .instr    (instr)
    );

    cpu_reg_file #(.DW(DW), .RW(RW)) reg_file1 (
        .CLK   (CLK),
        .we    (rf_we & wr_ok),
        .waddr (rf_to_r ? dec.imm[RW-1:0] : '0),
        .wdata (result),
        .raddr (dec.imm[RW-1:0]),
        .rdata (rr),
        .r0    (r0)
    );

    cpu_data_mem #(.DW(DW), .AW(8)) data_mem1 (
        .CLK   (CLK),
        .we    (mem_we & wr_ok),
        .addr  (rr),
        .wdata (r0),
        .rdata (mem_rdata)
    );

    cpu_alu alu (
        .op        (dec.op),
        .imm       (dec.imm),
        .r0        (r0),
        .rr        (rr),
        .mem_rdata (mem_rdata),
        .result    (result),
        .rf_we     (rf_we),
        .rf_to_r   (rf_to_r),
        .mem_we    (mem_we),
        .br_taken  (br_taken),
        .is_halt   (is_halt)
    );

    always_comb begin
        halt_d = halt_q | is_halt;
    end

    always_ff @(posedge CLK) begin
        if (start) halt_q <= 1'b0;
        else       halt_q <= halt_d;
    end

    assign Halt = halt_q;
endmodule

// File: tb/tb_top_level.sv
// Directed and randomized checks of the accumulator CPU, including the
// max-pairwise-Hamming-distance program against a behavioural model.
module tb_top_level;
    import cpu_pkg::*;

    logic CLK = 1'b0;
    logic start = 1'b1;
    logic Halt;
    int   vectors = 0;
    int   miscompares = 0;

    top_level dut (.CLK(CLK), .start(start), .Halt(Halt));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ins(input op_e o, input int v);
        logic [31:0] t;
        t = v;
        return {o, t[4:0]};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [8:0] p[$]);
        for (int i = 0; i < 256; i++) dut.IF.iROM.instruction_memory[i] = 9'd0;
        for (int i = 0; i < p.size(); i++) dut.IF.iROM.instruction_memory[i] = p[i];
    endtask

    task automatic run_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (Halt !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(Halt), 32'd1);
    endtask

    // Reference: brute force over every unordered pair.
    function automatic int ref_max(input logic [7:0] d[20]);
        int m;
        m = 0;
        for (int i = 0; i < 20; i++)
            for (int j = i + 1; j < 20; j++)
                if ($countones(d[i] ^ d[j]) > m) m = $countones(d[i] ^ d[j]);
        return m;
    endfunction

    logic [8:0] hprog[$];
    logic [8:0] prog[$];
    logic [7:0] dat[20];
    int         exp_pc[$];

    task automatic ham_setup();
        start = 1'b1;
        load(hprog);
        for (int i = 0; i < 20; i++) dut.data_mem1.my_memory[128+i] = dat[i];
        dut.data_mem1.my_memory[127] = 8'hEE;
        step();
        step();
        start = 1'b0;
    endtask

    initial begin
        hprog = '{
            ins(LDI,1),  ins(PUT,5),  ins(LDI,4),  ins(SHL,5),  ins(PUT,1),
            ins(LDI,20), ins(ADD,1),  ins(PUT,4),  ins(LDI,0),  ins(PUT,3),
            ins(LDI,16), ins(PUT,12), ins(LDI,19), ins(PUT,13), ins(LDI,31),
            ins(PUT,14),
            ins(GET,1),  ins(ADD,5),  ins(PUT,2),
            ins(LD,1),   ins(PUT,7),  ins(LD,2),   ins(XOR,7),  ins(PUT,8),
            ins(POPC,8), ins(PUT,9),  ins(GET,3),  ins(SLT,9),  ins(BEQZ,14),
            ins(GET,9),  ins(PUT,3),
            ins(GET,2),  ins(ADD,5),  ins(PUT,2),  ins(SUB,4),  ins(BNEZ,13),
            ins(GET,1),  ins(ADD,5),  ins(PUT,1),  ins(ADD,5),  ins(SUB,4),
            ins(BNEZ,12),
            ins(LDI,4),  ins(SHL,5),  ins(SUB,5),  ins(PUT,6),  ins(GET,3),
            ins(ST,6),   ins(HALT,0)
        };

        // Reset and immediate halt; start overrides a HALT at PC 0
        prog = '{ins(HALT,0)};
        load(prog);
        step();
        step();
        chk("rst_halt", 32'(Halt), 32'd0);
        chk("rst_pc", 32'(dut.IF.pc_q), 32'd0);
        start = 1'b0;
        step();
        chk("halt_rise", 32'(Halt), 32'd1);
        chk("halt_pc", 32'(dut.IF.pc_q), 32'd0);
        step();
        chk("halt_sticky", 32'(Halt), 32'd1);

        // Arithmetic and memory
        start = 1'b1;
        prog = '{ins(LDI,8), ins(SHL,4), ins(PUT,1), ins(LDI,5), ins(ST,1),
                 ins(ADD,1), ins(HALT,0)};
        load(prog);
        dut.data_mem1.my_memory[128] = 8'hAA;
        step();
        step();
        chk("start_clears_halt", 32'(Halt), 32'd0);
        start = 1'b0;
        run_halt("arith_halt", 20);
        chk("arith_r1", 32'(dut.reg_file1.registers[1]), 32'd128);
        chk("arith_mem128", 32'(dut.data_mem1.my_memory[128]), 32'd5);
        chk("arith_r0", 32'(dut.reg_file1.registers[0]), 32'd133);
        chk("arith_pc", 32'(dut.IF.pc_q), 32'd6);
        step();
        step();
        chk("frozen_pc", 32'(dut.IF.pc_q), 32'd6);
        chk("frozen_r0", 32'(dut.reg_file1.registers[0]), 32'd133);

        // POPC of XOR
        start = 1'b1;
        prog = '{ins(LDI,8), ins(SHL,4), ins(PUT,1), ins(LDI,1), ins(ADD,1),
                 ins(PUT,2), ins(LD,1), ins(PUT,3), ins(LD,2), ins(XOR,3),
                 ins(PUT,4), ins(POPC,4), ins(HALT,0)};
        load(prog);
        dut.data_mem1.my_memory[128] = 8'b0010_0100;
        dut.data_mem1.my_memory[129] = 8'b1000_0001;
        step();
        step();
        start = 1'b0;
        run_halt("popc_halt", 30);
        chk("xor_r4", 32'(dut.reg_file1.registers[4]), 32'hA5);
        chk("popc_r0", 32'(dut.reg_file1.registers[0]), 32'd4);

        // Branches, jump and SLT with a cycle-by-cycle PC trace
        start = 1'b1;
        prog = '{ins(LDI,9), ins(PUT,2), ins(LDI,14), ins(PUT,3), ins(LDI,0),
                 ins(BEQZ,2), ins(HALT,0), ins(HALT,0), ins(HALT,0),
                 ins(BNEZ,3), ins(LDI,1), ins(BEQZ,2), ins(BNEZ,3), ins(HALT,0),
                 ins(LDI,20), ins(PUT,4), ins(JMP,4), ins(HALT,0), ins(HALT,0),
                 ins(HALT,0),
                 ins(LDI,3), ins(PUT,5), ins(LDI,7), ins(PUT,6), ins(GET,5),
                 ins(SLT,6), ins(PUT,7), ins(GET,6), ins(SLT,5), ins(PUT,8),
                 ins(HALT,0)};
        load(prog);
        exp_pc = '{1, 2, 3, 4, 5, 9, 10, 11, 12, 14, 15, 16, 20,
                   21, 22, 23, 24, 25, 26, 27, 28, 29, 30};
        step();
        step();
        start = 1'b0;
        foreach (exp_pc[k]) begin
            step();
            chk($sformatf("br_pc[%0d]", k), 32'(dut.IF.pc_q), 32'(exp_pc[k]));
        end
        step();
        chk("br_halt", 32'(Halt), 32'd1);
        chk("br_halt_pc", 32'(dut.IF.pc_q), 32'd30);
        chk("slt_3_lt_7", 32'(dut.reg_file1.registers[7]), 32'd1);
        chk("slt_7_lt_3", 32'(dut.reg_file1.registers[8]), 32'd0);

        // Hamming program, case A
        for (int i = 0; i < 20; i++) dat[i] = 8'($urandom);
        dat[7]  = 8'h12;
        dat[12] = 8'hED;
        ham_setup();
        run_halt("hamA_halt", 10000);
        chk("hamA_model", 32'(dut.data_mem1.my_memory[127]), 32'(ref_max(dat)));
        chk("hamA_const", 32'(dut.data_mem1.my_memory[127]), 32'd8);

        // Case B
        for (int i = 0; i < 20; i++) dat[i] = 8'h00;
        dat[0] = 8'h24;
        dat[1] = 8'h81;
        ham_setup();
        run_halt("hamB_halt", 10000);
        chk("hamB_model", 32'(dut.data_mem1.my_memory[127]), 32'(ref_max(dat)));
        chk("hamB_const", 32'(dut.data_mem1.my_memory[127]), 32'd4);

        // Random data sets with sparse bits so the maximum varies
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 20; i++) dat[i] = 8'($urandom) & 8'($urandom);
            ham_setup();
            run_halt($sformatf("hamR%0d_halt", t), 10000);
            chk($sformatf("hamR%0d_model", t), 32'(dut.data_mem1.my_memory[127]),
                32'(ref_max(dat)));
        end

        // Reset in the middle of a run, then complete the rerun
        for (int i = 0; i < 20; i++) dat[i] = 8'($urandom);
        ham_setup();
        repeat (300) step();
        chk("mid_no_halt", 32'(Halt), 32'd0);
        start = 1'b1;
        step();
        chk("mid_pc0", 32'(dut.IF.pc_q), 32'd0);
        chk("mid_halt0", 32'(Halt), 32'd0);
        start = 1'b0;
        run_halt("mid_halt", 10000);
        chk("mid_model", 32'(dut.data_mem1.my_memory[127]), 32'(ref_max(dat)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
